uart_rx_fifo_less_param: RTL and testbench
==========================================

Name: uart_rx_fifo_less_param

Overview:
- Parametrised UART receiver. Successor to the fixed 8N1 receive wrapper.
- Integrates a runtime-programmable baud tick generator, an oversampling receive FSM and a one-word holding register.
- Supports configurable data bits, optional parity and configurable stop length.
- Read side uses a valid/ready handshake with per-word error flags, so the parent can consume words synchronously to clk.

Parameters:
- DBIT, 8: data bits per frame, legal 5..9, sent LSB first.
- OVS, 16: oversampling ticks per bit, even, legal 8..32.
- SB_TICK, 16: stop duration in ticks. 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- DIV_W, 16: width of baud_div.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high.
- rx, input, 1: serial line, asynchronous to clk, idle high.
- baud_div, input, DIV_W: tick period minus one. A tick occurs every baud_div+1 clk cycles.
- rx_data, output, DBIT: held received word.
- rx_valid, output, 1: rx_data and the flags are valid.
- rx_ready, input, 1: consumer accepts the word. A transfer occurs when rx_valid && rx_ready.
- frame_err, output, 1: stop bit of the held word sampled low.
- parity_err, output, 1: parity mismatch on the held word. Always 0 when PARITY_EN = 0.
- overrun, output, 1: at least one later word was dropped while this word was held.
- busy, output, 1: FSM not in IDLE.

Behaviour:
- Reset values:
  - rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun = 0, busy = 0.
  - FSM = IDLE, all counters = 0.
  - Synchronizer flops = 1; the armed flag = 1.
- Reset mid-frame aborts the frame immediately. No partial word is delivered.
- Synchronizer: rx passes through 2 flops before any use. This adds 2 clk of latency.
- Tick generator:
  - Free-running counter; it wraps to 0 and pulses s_tick for 1 clk when count >= baud_div.
  - baud_div = 0 gives s_tick every cycle.
  - A baud_div change takes effect at the next wrap. baud_div must be stable during a frame; a mid-frame change is not defined.
- FSM states and transitions (counter s counts s_tick, n counts bits):
  - IDLE: if rx_s == 0 and armed, go to START with s = 0. rx_s == 1 sets armed.
  - START: on tick at s == OVS/2-1, check rx_s.
    - rx_s == 0: go to DATA with s = 0, n = 0.
    - rx_s == 1: glitch, return to IDLE. Nothing is delivered.
  - DATA: on tick at s == OVS-1, shift rx_s into the MSB of the shift register, set s = 0, n++.
    - After DBIT bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: on tick at s == OVS-1, compute parity_bad = ^{data, rx_s} ^ PARITY_ODD, then go to STOP.
  - STOP: on tick at s == SB_TICK-1, set frame_bad = !rx_s, then go to IDLE.
    - If frame_bad, clear armed, so a break produces exactly one word.
- Completion is the cycle of the final STOP tick. rx_valid rises on the following clk edge.
- Holding register:
  - At completion, if the register is empty or being drained in the same cycle: load the data, frame_err and parity_err; set overrun = 0 and rx_valid = 1.
  - At completion, if the register is full and not draining: keep the held word and set its overrun = 1. The new word is lost.
  - A transfer without a simultaneous load clears rx_valid and all flags to 0. rx_data holds its value.
- A frame with an error is still delivered, with the corresponding flag set.

Decomposition:
- Package uart_pkg holds:
  - The FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - Stop-tick constants: SB_1 = 16, SB_1P5 = 24, SB_2 = 32.
  - Default baud divisors for a 50 MHz clk at 16x: 19200 -> 162, 115200 -> 26.
- One sub-module: uart_baud_gen, the tick generator. Ports: clk, reset, baud_div, s_tick.
- The synchronizer, FSM and holding register stay in the top module.

Test Plan:
- Basic frame: baud_div = 3, OVS = 16 (64 clk/bit), 8N1. Send 0xA5 with rx_ready = 1 -> rx_data = 0xA5, rx_valid high 1 clk, all flags 0, busy low afterwards.
- Parity: PARITY_EN = 1, even parity. Send 0x03 with a correct parity bit (0) -> parity_err = 0. Send 0x03 with parity bit 1 -> rx_data = 0x03, parity_err = 1.
- Framing and break: hold rx low for 12 bit times -> exactly one word, rx_data = 0x00, frame_err = 1. No second word until rx returns high and a new start bit is sent.
- Overrun: rx_ready = 0. Send 0x11, 0x22, 0x33 -> rx_data = 0x11, overrun = 1. Raise rx_ready for 1 clk -> rx_valid = 0, overrun = 0.
- Simultaneous drain and load: with 0x11 held, assert rx_ready exactly in the completion cycle of 0x22 -> next cycle rx_data = 0x22, rx_valid = 1, overrun = 0.
- Glitch and reset: a 20-clk low pulse on rx -> no word delivered and busy returns low. Assert reset during DATA of 0x5A -> outputs go to reset values; the next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
// FSM state encoding, stop-length tick counts and default baud divisors.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Stop duration in oversample ticks at 16x.
  localparam int SB_1   = 16;
  localparam int SB_1P5 = 24;
  localparam int SB_2   = 32;

  // baud_div values for a 50 MHz clk at 16x oversampling.
  localparam int DIV_19200  = 162;
  localparam int DIV_115200 = 26;

endpackage

// File: rtl/uart_rx_fifo_less_param_baud_gen.sv
// Runtime-programmable oversample tick generator.
// Ports: clk, reset, baud_div (period-1), s_tick (1-clk pulse).
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_div,
  output logic             s_tick
);

  logic [DIV_W-1:0] count;

  // Compare with >= so a divisor lowered below the
  // current count still wraps on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      s_tick <= 1'b0;
    end else if (count >= baud_div) begin
      count  <= '0;
      s_tick <= 1'b1;
    end else begin
      count  <= count + 1'b1;
      s_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_less_param.sv
// Parametrised UART receiver: 2-flop sync, oversampling FSM, one-word hold.
// Ports: clk, reset, rx, baud_div in; rx_data/rx_valid/rx_ready handshake,
// frame_err, parity_err, overrun, busy out.
module uart_rx_fifo_less_param
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVS        = 16,
  parameter int SB_TICK    = 16,
  parameter int DIV_W      = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  output logic [DBIT-1:0]  rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy
);

  localparam logic [5:0] S_MID  = 6'(OVS/2 - 1);
  localparam logic [5:0] S_BIT  = 6'(OVS - 1);
  localparam logic [5:0] S_STOP = 6'(SB_TICK - 1);
  localparam logic [3:0] N_LAST = 4'(DBIT - 1);
  localparam logic       ODD    = 1'(PARITY_ODD);
  localparam logic       PEN    = (PARITY_EN != 0);

  logic            s_tick;
  logic [1:0]      sync_q;
  logic            rx_s;
  state_t          state, state_n;
  logic [5:0]      s, s_n;
  logic [3:0]      n, n_n;
  logic [DBIT-1:0] sh, sh_n;
  logic            armed, armed_n;
  logic            par_bad, par_bad_n;
  logic            done;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .baud_div (baud_div),
    .s_tick   (s_tick)
  );

  assign rx_s = sync_q[1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      sh      <= '0;
      armed   <= 1'b1;
      par_bad <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state   <= state_n;
      s       <= s_n;
      n       <= n_n;
      sh      <= sh_n;
      armed   <= armed_n;
      par_bad <= par_bad_n;
    end
  end

  always_comb begin
    state_n   = state;
    s_n       = s;
    n_n       = n;
    sh_n      = sh;
    armed_n   = armed;
    par_bad_n = par_bad;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_s) begin
          armed_n = 1'b1;
        end else if (armed) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state_n   = DATA;
              s_n       = '0;
              n_n       = '0;
              par_bad_n = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_n  = '0;
            sh_n = {rx_s, sh[DBIT-1:1]};
            if (n == N_LAST) begin
              state_n = PEN ? PARITY : STOP;
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_n       = '0;
            par_bad_n = (^{sh, rx_s}) ^ ODD;
            state_n   = STOP;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            done    = 1'b1;
            state_n = IDLE;
            // A low stop means a break may follow: wait for
            // the line to go high before accepting a start.
            if (!rx_s) armed_n = 1'b0;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (done && (!rx_valid || rx_ready)) begin
      rx_data    <= sh;
      rx_valid   <= 1'b1;
      frame_err  <= !rx_s;
      parity_err <= PEN && par_bad;
      overrun    <= 1'b0;
    end else if (done) begin
      overrun <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_less_param.sv
// Directed bench for uart_rx_fifo_less_param (8N1 and 8E1 instances).
// baud_div = 3, OVS = 16: 64 clk per bit.
module tb_uart_rx_fifo_less_param;

  localparam int BIT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic        rdy = 1'b1;
  logic        rx0 = 1'b1;
  logic        rx1 = 1'b1;

  logic [7:0] d0, d1;
  logic v0, fe0, pe0, ov0, b0;
  logic v1, fe1, pe1, ov1, b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_less_param dut (
    .clk(clk), .reset(reset), .rx(rx0), .baud_div(baud_div),
    .rx_data(d0), .rx_valid(v0), .rx_ready(rdy),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(b0)
  );

  uart_rx_fifo_less_param #(.PARITY_EN(1)) dut_p (
    .clk(clk), .reset(reset), .rx(rx1), .baud_div(baud_div),
    .rx_data(d1), .rx_valid(v1), .rx_ready(rdy),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(b1)
  );

  // Capture each delivered word on its rising rx_valid.
  int cnt0 = 0, hi0 = 0, cnt1 = 0;
  logic [7:0] cd0 = '0, cd1 = '0;
  logic cfe0 = 0, cpe0 = 0, cov0 = 0, cfe1 = 0, cpe1 = 0;
  logic v0q = 0, v1q = 0;

  always @(negedge clk) begin
    if (v0 && !v0q) begin
      cnt0++; cd0 = d0; cfe0 = fe0; cpe0 = pe0; cov0 = ov0;
    end
    if (v0) hi0++;
    v0q = v0;
    if (v1 && !v1q) begin
      cnt1++; cd1 = d1; cfe1 = fe1; cpe1 = pe1;
    end
    v1q = v1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic send(input int which, input logic [10:0] bits,
                      input int nb);
    for (int i = 0; i < nb; i++) begin
      if (which == 0) rx0 = bits[i];
      else rx1 = bits[i];
      idle(BIT);
    end
  endtask

  function automatic logic [10:0] frm(input logic [7:0] d);
    return {2'b11, d, 1'b0};
  endfunction

  function automatic logic [10:0] frmp(input logic [7:0] d,
                                       input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  int c, h, k;

  initial begin
    idle(3);
    check("rst_valid", v0, 0);
    check("rst_data", d0, 0);
    check("rst_busy", b0, 0);
    check("rst_ferr", fe0, 0);
    check("rst_ovr", ov0, 0);
    reset = 1'b0;
    idle(20);

    // Basic 8N1 frame
    c = cnt0; h = hi0;
    send(0, frm(8'hA5), 10);
    idle(BIT);
    check("basic_cnt", cnt0 - c, 1);
    check("basic_data", cd0, 8'hA5);
    check("basic_ferr", cfe0, 0);
    check("basic_perr", cpe0, 0);
    check("basic_ovr", cov0, 0);
    check("basic_pulse", hi0 - h, 1);
    check("basic_busy", b0, 0);

    // Even parity
    c = cnt1;
    send(1, frmp(8'h03, 1'b0), 11);
    idle(BIT);
    check("par_ok_cnt", cnt1 - c, 1);
    check("par_ok_data", cd1, 8'h03);
    check("par_ok_perr", cpe1, 0);
    check("par_ok_ferr", cfe1, 0);
    send(1, frmp(8'h03, 1'b1), 11);
    idle(BIT);
    check("par_bad_cnt", cnt1 - c, 2);
    check("par_bad_data", cd1, 8'h03);
    check("par_bad_perr", cpe1, 1);

    // Break: 12 bit times low
    c = cnt0;
    rx0 = 1'b0;
    idle(12 * BIT);
    rx0 = 1'b1;
    idle(2 * BIT);
    check("brk_cnt", cnt0 - c, 1);
    check("brk_data", cd0, 8'h00);
    check("brk_ferr", cfe0, 1);
    check("brk_busy", b0, 0);
    send(0, frm(8'h3C), 10);
    idle(BIT);
    check("brk_next_cnt", cnt0 - c, 2);
    check("brk_next_data", cd0, 8'h3C);
    check("brk_next_ferr", cfe0, 0);

    // Overrun
    rdy = 1'b0;
    send(0, frm(8'h11), 10);
    send(0, frm(8'h22), 10);
    send(0, frm(8'h33), 10);
    idle(BIT);
    check("ovr_valid", v0, 1);
    check("ovr_data", d0, 8'h11);
    check("ovr_flag", ov0, 1);
    rdy = 1'b1;
    idle(1);
    rdy = 1'b0;
    check("ovr_drain_valid", v0, 0);
    check("ovr_drain_flag", ov0, 0);
    check("ovr_drain_data", d0, 8'h11);

    // Drain and load in the same cycle
    send(0, frm(8'h11), 10);
    idle(BIT);
    check("dl_hold", d0, 8'h11);
    k = 0;
    fork
      send(0, frm(8'h22), 10);
      begin
        while (!dut.done && k < 2000) begin
          idle(1);
          k++;
        end
        check("dl_seen", 32'(k < 2000), 1);
        rdy = 1'b1;
        idle(1);
        rdy = 1'b0;
        check("dl_data", d0, 8'h22);
        check("dl_valid", v0, 1);
        check("dl_ovr", ov0, 0);
      end
    join
    idle(BIT);

    // Glitch
    c = cnt0;
    rx0 = 1'b0;
    idle(10);
    check("gl_busy_hi", b0, 1);
    idle(10);
    rx0 = 1'b1;
    idle(100);
    check("gl_cnt", cnt0 - c, 0);
    check("gl_busy_lo", b0, 0);

    // Reset during DATA
    fork
      send(0, frm(8'h5A), 10);
      begin
        idle(250);
        reset = 1'b1;
        idle(1);
        check("mr_valid", v0, 0);
        check("mr_data", d0, 0);
        check("mr_busy", b0, 0);
        check("mr_ovr", ov0, 0);
      end
    join
    check("mr_cnt", cnt0 - c, 0);
    reset = 1'b0;
    rdy = 1'b1;
    idle(BIT);
    send(0, frm(8'h5A), 10);
    idle(BIT);
    check("mr_next_cnt", cnt0 - c, 1);
    check("mr_next_data", cd0, 8'h5A);
    check("mr_next_ferr", cfe0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
